// File: rtl/alu_cmd_sequencer.sv
// Command/response front end for the registered 4-bit ALU: issues one operation,
// waits ALU_LATENCY edges, captures the result. Optional macro ALU_SEQ_STATS_EN adds counters.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_op,
    output logic       rsp_zero,
    output logic       rsp_neg,
    output logic       busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] zero_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

    function automatic logic flag_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

    function automatic logic flag_neg(input logic [7:0] v);
        return v[7];
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [3:0] alu_s_q, alu_s_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [3:0] rsp_op_q, rsp_op_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_neg_q, rsp_neg_d;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] zero_count_q, zero_count_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_neg_d   = rsp_neg_q;
`ifdef ALU_SEQ_STATS_EN
        op_count_d   = op_count_q;
        zero_count_d = zero_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = WAIT;
                    cnt_d   = LAT_LOAD;
                    alu_a_d = cmd_a;
                    alu_b_d = cmd_b;
                    alu_s_d = cmd_op;
                end
            end
            WAIT: begin
                // alu_s still holds the issued opcode, so it tags the captured result
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_out;
                    rsp_op_d    = alu_s_q;
                    rsp_zero_d  = flag_zero(alu_out);
                    rsp_neg_d   = flag_neg(alu_out);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
`ifdef ALU_SEQ_STATS_EN
                    op_count_d = op_count_q + 16'd1;
                    if (rsp_zero_q) begin
                        zero_count_d = zero_count_q + 16'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_s_q     <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_op_q    <= 4'd0;
            rsp_zero_q  <= 1'b0;
            rsp_neg_q   <= 1'b0;
`ifdef ALU_SEQ_STATS_EN
            op_count_q   <= 16'd0;
            zero_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_neg_q   <= rsp_neg_d;
`ifdef ALU_SEQ_STATS_EN
            op_count_q   <= op_count_d;
            zero_count_q <= zero_count_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_neg   = rsp_neg_q;
`ifdef ALU_SEQ_STATS_EN
    assign op_count   = op_count_q;
    assign zero_count = zero_count_q;
`endif

endmodule
